// File: rtl/clut_lookup.sv
// clut_lookup: palette stage behind the CLUT7 RLE decompressor.
// Maps 8-bit colour indices through a 256 x 24 palette RAM to RGB888 pixels.
// It also tracks the pixel position within the line and flags the last pixel.
module clut_lookup #(
  parameter int unsigned LINE_PIXELS = 384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_reset,
  input  logic        clut_bank,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_write,
  output logic        pixel_in_strobe,
  input  logic        clut_wr,
  input  logic [7:0]  clut_wr_addr,
  input  logic [23:0] clut_wr_data,
  output logic [23:0] rgb,
  output logic        rgb_write,
  input  logic        rgb_strobe,
  output logic        rgb_last
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned POS_W  = 11;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LINE_PIXELS - 1);

  // Palette storage and its registered read port (not reset: contents survive reset)
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata;

  logic [ADDR_W-1:0] rd_addr;
  logic              in_xfer;
  logic              out_xfer;

  logic              out_valid_q;
  logic              out_valid_d;
  logic [POS_W-1:0]  pos_q;
  logic [POS_W-1:0]  pos_d;

  // Handshake decode; bank bit forces the upper palette half for plane B
  always_comb begin
    rd_addr         = {pixel_in[7] | clut_bank, pixel_in[6:0]};
    pixel_in_strobe = pixel_in_write & (~out_valid_q | rgb_strobe) & ~line_reset;
    in_xfer         = pixel_in_strobe;
    out_xfer        = out_valid_q & rgb_strobe;
  end

  // Palette write port; writes are honoured even under reset or line_reset
  always_ff @(posedge clk) begin
    if (clut_wr) begin
      mem[clut_wr_addr] <= clut_wr_data;
    end
  end

  // Read port: enabled only on accept so the output holds under backpressure.
  // Read-first on a same-address collision falls out of the non-blocking write.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      ram_rdata <= mem[rd_addr];
    end
  end

  // Output-stage occupancy and line position next-state
  always_comb begin
    out_valid_d = out_valid_q;
    pos_d       = pos_q;

    if (in_xfer) begin
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    if (out_xfer) begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    end

    if (line_reset) begin
      out_valid_d = 1'b0;
      pos_d       = '0;
    end
  end

  // State registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      pos_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pos_q       <= pos_d;
    end
  end

  // Output presentation: colour is forced to black while the stage is empty
  always_comb begin
    rgb_write = out_valid_q;
    rgb       = out_valid_q ? ram_rdata : '0;
    rgb_last  = out_valid_q & (pos_q == POS_LAST);
  end

endmodule

// File: tb/tb_clut_lookup.sv
// tb_clut_lookup: scoreboard bench for clut_lookup.
// The driver pushes expected colours on each accept; a monitor pops them on output transfers.
module tb_clut_lookup;

  localparam int LINE_PIXELS = 384;

  logic        clk;
  logic        reset;
  logic        line_reset;
  logic        clut_bank;
  logic [7:0]  pixel_in;
  logic        pixel_in_write;
  logic        pixel_in_strobe;
  logic        clut_wr;
  logic [7:0]  clut_wr_addr;
  logic [23:0] clut_wr_data;
  logic [23:0] rgb;
  logic        rgb_write;
  logic        rgb_strobe;
  logic        rgb_last;

  clut_lookup #(.LINE_PIXELS(LINE_PIXELS)) dut (
    .clk             (clk),
    .reset           (reset),
    .line_reset      (line_reset),
    .clut_bank       (clut_bank),
    .pixel_in        (pixel_in),
    .pixel_in_write  (pixel_in_write),
    .pixel_in_strobe (pixel_in_strobe),
    .clut_wr         (clut_wr),
    .clut_wr_addr    (clut_wr_addr),
    .clut_wr_data    (clut_wr_data),
    .rgb             (rgb),
    .rgb_write       (rgb_write),
    .rgb_strobe      (rgb_strobe),
    .rgb_last        (rgb_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int n_last = 0;

  logic [23:0] shadow [256];
  logic [23:0] exp_q [$];
  logic [23:0] exp_v;

  // Staged stimulus applied by step()
  logic        s_w, s_bank, s_os, s_cw, s_lr, s_rs;
  logic [7:0]  s_idx, s_ca;
  logic [23:0] s_cd;
  logic        acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_idle();
    s_w = 1'b0; s_idx = 8'd0; s_bank = 1'b0; s_os = 1'b1;
    s_cw = 1'b0; s_ca = 8'd0; s_cd = 24'd0; s_lr = 1'b0; s_rs = 1'b0;
  endtask

  // One clock: drive staged inputs just after the edge, then update the reference model
  task automatic step(output logic accepted);
    @(posedge clk);
    #1;
    pixel_in_write = s_w;  pixel_in = s_idx;  clut_bank = s_bank;
    rgb_strobe = s_os;     clut_wr = s_cw;    clut_wr_addr = s_ca;
    clut_wr_data = s_cd;   line_reset = s_lr; reset = s_rs;
    #2;
    accepted = pixel_in_write && pixel_in_strobe;
    if (accepted) exp_q.push_back(shadow[{s_idx[7] | s_bank, s_idx[6:0]}]);
    if (s_cw) shadow[s_ca] = s_cd;
    if (s_lr || s_rs) begin
      exp_q.delete();
      n_out = 0;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    set_idle();
    s_cw = 1'b1; s_ca = a; s_cd = d;
    step(acc);
  endtask

  task automatic send(input logic [7:0] idx, input logic bank);
    set_idle();
    s_w = 1'b1; s_idx = idx; s_bank = bank;
    step(acc);
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    set_idle();
    while (exp_q.size() != 0 && k < 50) begin
      step(acc);
      k++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  // Monitor: every output transfer must match the oldest expected colour and line position
  always @(negedge clk) begin
    if (rgb_write === 1'b1 && rgb_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got rgb=%h want no output", rgb);
      end else begin
        exp_v = exp_q.pop_front();
        chk("rgb", 32'(rgb), 32'(exp_v));
        chk("rgb_last", 32'(rgb_last), 32'((n_out % LINE_PIXELS) == LINE_PIXELS - 1));
        if (rgb_last) n_last++;
        n_out++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic pend;
    set_idle();
    s_os = 1'b0;
    pixel_in_write = 1'b0; pixel_in = 8'd0; clut_bank = 1'b0; rgb_strobe = 1'b0;
    clut_wr = 1'b0; clut_wr_addr = 8'd0; clut_wr_data = 24'd0; line_reset = 1'b0; reset = 1'b1;

    // Palette fill while reset is held
    for (int i = 0; i < 256; i++) begin
      set_idle();
      s_os = 1'b0; s_rs = 1'b1; s_cw = 1'b1; s_ca = 8'(i); s_cd = 24'($urandom);
      step(acc);
    end

    // Reset state, first cycle out of reset with a pending index
    set_idle();
    s_w = 1'b1; s_idx = 8'd0;
    step(acc);
    chk("reset_rgb_write", 32'(rgb_write), 32'd0);
    chk("reset_rgb", 32'(rgb), 32'd0);
    chk("reset_rgb_last", 32'(rgb_last), 32'd0);
    chk("reset_strobe", 32'(acc), 32'd1);
    drain();

    // Streaming lookup, no bubbles
    wr(8'd5, 24'h112233);
    wr(8'd133, 24'hAABBCC);
    send(8'd5, 1'b0);
    send(8'd133, 1'b0);
    chk("stream_valid1", 32'(rgb), 32'h112233);
    send(8'd5, 1'b0);
    chk("stream_valid2", 32'(rgb), 32'hAABBCC);
    drain();

    // Bank select
    send(8'd5, 1'b1);
    chk("bank_rgb", 32'(rgb_write), 32'd0);
    set_idle(); s_os = 1'b0; step(acc);
    chk("bank_value", 32'(rgb), 32'hAABBCC);
    drain();

    // Backpressure: hold output for 4 cycles, producer holds index 2
    wr(8'd1, 24'h010101);
    wr(8'd2, 24'h020202);
    wr(8'd3, 24'h030303);
    send(8'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_idle(); s_w = 1'b1; s_idx = 8'd2; s_os = 1'b0;
      step(acc);
      chk("bp_strobe", 32'(acc), 32'd0);
      chk("bp_rgb", 32'(rgb), 32'h010101);
    end
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    drain();

    // Collision: read-first on a same-address write
    wr(8'd9, 24'h000001);
    set_idle(); s_w = 1'b1; s_idx = 8'd9; s_cw = 1'b1; s_ca = 8'd9; s_cd = 24'hFFFFFF;
    step(acc);
    chk("coll_accept", 32'(acc), 32'd1);
    send(8'd9, 1'b0);
    chk("coll_old", 32'(rgb), 32'h000001);
    drain();

    // Line counting: 385 transfers from a fresh line
    set_idle(); s_lr = 1'b1; s_os = 1'b0; step(acc);
    base = n_last;
    for (int i = 0; i < LINE_PIXELS + 1; i++) send(8'($urandom), 1'($urandom));
    drain();
    chk("line_last_count", 32'(n_last - base), 32'd1);

    // line_reset after 100 pixels, then a full line
    base = n_last;
    for (int i = 0; i < 100; i++) send(8'($urandom), 1'b0);
    drain();
    set_idle(); s_lr = 1'b1; s_os = 1'b0; s_w = 1'b1;
    step(acc);
    chk("lr_no_accept", 32'(acc), 32'd0);
    for (int i = 0; i < LINE_PIXELS; i++) send(8'($urandom), 1'b0);
    drain();
    chk("lr_last_count", 32'(n_last - base), 32'd1);

    // Reset mid-stream while stalled
    send(8'd5, 1'b0);
    set_idle(); s_os = 1'b0; step(acc);
    chk("stall_valid", 32'(rgb_write), 32'd1);
    set_idle(); s_os = 1'b0; s_rs = 1'b1; step(acc);
    set_idle(); s_os = 1'b0; step(acc);
    chk("midrst_write", 32'(rgb_write), 32'd0);
    chk("midrst_rgb", 32'(rgb), 32'd0);
    chk("midrst_last", 32'(rgb_last), 32'd0);
    send(8'd5, 1'b0);
    send(8'd133, 1'b0);
    send(8'd9, 1'b0);
    drain();

    // Randomized traffic with palette writes and occasional line resets
    pend = 1'b0;
    set_idle();
    for (int i = 0; i < 2000; i++) begin
      s_os = ($urandom_range(3) != 0);
      s_cw = ($urandom_range(3) == 0);
      s_ca = 8'($urandom);
      s_cd = 24'($urandom);
      s_lr = ($urandom_range(96) == 0);
      s_rs = 1'b0;
      if (s_lr) s_os = 1'b0;
      if (!pend) begin
        s_w    = ($urandom_range(2) != 0);
        s_idx  = 8'($urandom);
        s_bank = 1'($urandom);
      end
      step(acc);
      pend = s_w && !acc;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clut_lookup.md
# clut_lookup

Palette stage directly downstream of the CLUT7 RLE decompressor. Consumes 8-bit colour indices over the same write/strobe handshake, looks each one up in a 256 × 24-bit colour lookup table and emits one RGB888 pixel per accepted index toward the plane mixer. Also tracks the pixel position within the line and flags the last pixel. The palette is loaded through a separate write port driven by the register/DCA logic.

## Interface
- `LINE_PIXELS`, default 384: pixels per display line, used by the position counter and `rgb_last`.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `line_reset`, in, 1: synchronous; starts a new line; flushes the pipeline and clears the position counter.
- `clut_bank`, in, 1: index bit 7 override; 1 selects entries 128–255 for CLUT7 plane B.
- `pixel_in`, in, 8: colour index from the RLE stage.
- `pixel_in_write`, in, 1: `pixel_in` valid.
- `pixel_in_strobe`, out, 1: index accepted this cycle.
- `clut_wr`, in, 1: palette write enable.
- `clut_wr_addr`, in, 8: palette entry address.
- `clut_wr_data`, in, 24: palette entry data, {R,G,B}.
- `rgb`, out, 24: looked-up colour.
- `rgb_write`, out, 1: `rgb` valid.
- `rgb_strobe`, in, 1: downstream accepts `rgb`.
- `rgb_last`, out, 1: the current `rgb` is pixel `LINE_PIXELS`-1 of the line.

## Operation
- **Transfer rule, both sides:** a transfer occurs in a cycle where write=1 and strobe=1. A producer must hold data stable while write=1 and strobe=0.
- **Read address:** effective address = {`pixel_in[7]` | `clut_bank`, `pixel_in[6:0]`}.
- **Palette RAM:** 256 × 24, one write port and one registered read port.
  - The read enable is asserted only on an input transfer, so the RAM output holds while the stage is stalled.
- **Pipeline:** one output stage, tracked by the `out_valid` register.
  - `pixel_in_strobe` = `pixel_in_write` & (!`out_valid` | `rgb_strobe`) & !`line_reset`. This is combinational.
  - On an input transfer, `out_valid` <= 1.
  - Else, on an output transfer, `out_valid` <= 0.
  - Simultaneous input and output transfers keep `out_valid` at 1 and give full throughput.
- **Outputs:**
  - `rgb_write` = `out_valid`.
  - `rgb` = RAM output when `out_valid`=1; `rgb` = 24'h000000 when `out_valid`=0.
- **Write/read collision** (same address, same cycle): read-first. The read returns the old entry; the new entry is visible from the next read.
- **Position counter** `pos`, 11 bits:
  - Increments on each output transfer.
  - Wraps to 0 after `LINE_PIXELS`-1.
  - `rgb_last` = `out_valid` & (`pos` == `LINE_PIXELS`-1).
- **`line_reset`:** `out_valid` <= 0, `pos` <= 0, and no input is accepted that cycle. Palette contents are unaffected.
- **`reset`:** `out_valid`=0, `pos`=0. Palette contents are not cleared; RAM contents are undefined after power-up until written.
- **Priority:** `reset` > `line_reset` > transfers. Palette writes proceed during `line_reset`, and during `reset` if `clut_wr`=1.

## Timing
- **Reset values:** `rgb_write`=0, `rgb`=0, `rgb_last`=0. `pixel_in_strobe` follows its equation, so it reads 1 if `pixel_in_write`=1.
- **Latency:** index accepted in cycle N → `rgb` valid in cycle N+1.
- **Throughput:** 1 pixel/cycle with `rgb_strobe` held at 1.
- **Backpressure:** while `rgb_write`=1 and `rgb_strobe`=0:
  - `pixel_in_strobe`=0;
  - `rgb` and `rgb_last` are held unchanged.
- **Bubble:** `pixel_in_write`=0 with an output transfer → `rgb_write`=0 next cycle.
- **Counter wrap:** the output transfer with `rgb_last`=1 sets `pos` to 0 in the next cycle.
- **Palette write timing:** a write in cycle N is visible to reads issued in cycle N+1 or later.

## Test plan
1. **Streaming lookup.**
   - Stimulus: write entry 5 = 24'h112233 and entry 133 = 24'hAABBCC; stream indices 5, 133, 5 with `rgb_strobe`=1 and `clut_bank`=0.
   - Required: `rgb` = 112233, AABBCC, 112233 on consecutive cycles, starting one cycle after the first accept; no bubbles.
2. **Bank select.**
   - Stimulus: `clut_bank`=1, index 5.
   - Required: `rgb`=AABBCC.
3. **Backpressure.**
   - Stimulus: stream 1, 2, 3 (entry n = n·24'h010101); hold `rgb_strobe`=0 for 4 cycles after the first output.
   - Required: `rgb`=010101 held for those 4 cycles; `pixel_in_strobe`=0 throughout; then 020202 and 030303; no loss or duplication.
4. **Line counting.**
   - Stimulus: 384 consecutive transfers, then 1 more.
   - Required: `rgb_last`=1 only on transfer 384; transfer 385 has `rgb_last`=0.
   - Stimulus: `line_reset` after 100 pixels, then 384 more.
   - Required: `rgb_last` on the 384th pixel after `line_reset`.
5. **Collision.**
   - Stimulus: entry 9 = 24'h000001; in the same cycle, write 24'hFFFFFF to entry 9 and accept index 9; then accept index 9 again.
   - Required: 000001, then FFFFFF.
6. **Reset mid-stream.**
   - Stimulus: assert `reset` while `rgb_write`=1 and `rgb_strobe`=0.
   - Required: next cycle `rgb_write`=0, `rgb`=0, `rgb_last`=0; palette entries written before the reset read back unchanged.
